enemy_fleet: RTL and testbench

Parametrised successor to the single-ship enemy: one block owns an entire ROWS_P x COLS_P invader formation. It holds a shared formation origin, per-ship alive bits, and a frame-paced march/descend state machine. It also fires one enemy bullet at a time from the front (lowest alive) ship of a round-robin column. It sits between the frame-tick generator, the collision logic and the VGA renderer.

---
 rtl/enemy_fleet.sv | 245 ++++++++++++++++++++++++
 tb/tb_enemy_fleet.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/enemy_fleet.sv
// rtl/enemy_fleet.sv - invader formation: shared origin, alive bits, march/descend FSM, single enemy bullet
// Optional FLEET_SPEEDUP_EN shortens the move period as ships are destroyed.
module enemy_fleet #(
    parameter int ROWS_P        = 4,
    parameter int COLS_P        = 8,
    parameter int SHIP_W_P      = 40,
    parameter int SHIP_H_P      = 20,
    parameter int COL_PITCH_P   = 50,
    parameter int ROW_PITCH_P   = 30,
    parameter int START_X_P     = 9,
    parameter int START_Y_P     = 9,
    parameter int LEFT_BOUND_P  = 9,
    parameter int RIGHT_BOUND_P = 629,
    parameter int LAND_Y_P      = 420,
    parameter int STEP_X_P      = 10,
    parameter int STEP_Y_P      = 10,
    parameter int MOVE_FRAMES_P = 30,
    parameter int FIRE_FRAMES_P = 120,
    parameter int BULLET_STEP_P = 5,
    parameter int BULLET_BOT_P  = 479
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic                        frame_i,
    input  logic                        start_i,
    input  logic                        hit_i,
    input  logic [$clog2(ROWS_P)-1:0]   hit_row_i,
    input  logic [$clog2(COLS_P)-1:0]   hit_col_i,
    input  logic                        bullet_clear_i,
    output logic [9:0]                  origin_x_o,
    output logic [9:0]                  origin_y_o,
    output logic [ROWS_P*COLS_P-1:0]    alive_o,
    output logic                        dir_right_o,
    output logic                        all_dead_o,
    output logic                        landed_o,
    output logic                        bullet_valid_o,
    output logic [9:0]                  bullet_x_o,
    output logic [9:0]                  bullet_y_o
);

    localparam int N     = ROWS_P * COLS_P;
    localparam int ROW_W = $clog2(ROWS_P);
    localparam int COL_W = $clog2(COLS_P);
    localparam int MC_W  = $clog2(MOVE_FRAMES_P);
    localparam int FC_W  = $clog2(FIRE_FRAMES_P);

    localparam logic [9:0] L_START_X = 10'(START_X_P);
    localparam logic [9:0] L_START_Y = 10'(START_Y_P);
    localparam logic [9:0] L_LEFT    = 10'(LEFT_BOUND_P);
    localparam logic [9:0] L_RIGHT   = 10'(RIGHT_BOUND_P);
    localparam logic [9:0] L_LAND    = 10'(LAND_Y_P);
    localparam logic [9:0] L_STEP_X  = 10'(STEP_X_P);
    localparam logic [9:0] L_STEP_Y  = 10'(STEP_Y_P);
    localparam logic [9:0] L_BSTEP   = 10'(BULLET_STEP_P);
    localparam logic [9:0] L_BBOT    = 10'(BULLET_BOT_P);

    typedef enum logic [2:0] {IDLE, MARCH, DESCEND, CLEARED, LANDED} state_t;

    state_t           r_state;
    logic [9:0]       r_origin_x, r_origin_y;
    logic [N-1:0]     r_alive;
    logic             r_dir_right, r_all_dead, r_landed;
    logic             r_bullet_valid;
    logic [9:0]       r_bullet_x, r_bullet_y;
    logic [MC_W-1:0]  r_move_cnt;
    logic [FC_W-1:0]  r_fire_cnt;
    logic [COL_W-1:0] r_fire_ptr;

    logic [COLS_P-1:0] w_col_alive;
    logic [COL_W-1:0]  w_lc, w_rc, w_fire_col, w_next_ptr;
    logic [ROW_W-1:0]  w_br, w_fire_row;
    logic [9:0]        w_left, w_right, w_new_bottom, w_spawn_x, w_spawn_y, w_bullet_next;
    logic              w_at_edge, w_fire_found, w_move_last, w_active;
    logic [N-1:0]      w_alive_hit;

    // Extents consider only columns/rows that still hold a live ship.
    always_comb begin
        w_col_alive = '0;
        w_lc        = '0;
        w_rc        = '0;
        w_br        = '0;
        for (int r = 0; r < ROWS_P; r++) begin
            for (int c = 0; c < COLS_P; c++) begin
                if (r_alive[r*COLS_P + c]) begin
                    w_col_alive[c] = 1'b1;
                    w_br           = ROW_W'(r);
                end
            end
        end
        for (int c = COLS_P - 1; c >= 0; c--) begin
            if (w_col_alive[c]) w_lc = COL_W'(c);
        end
        for (int c = 0; c < COLS_P; c++) begin
            if (w_col_alive[c]) w_rc = COL_W'(c);
        end
    end

    assign w_left       = r_origin_x + 10'(int'(w_lc) * COL_PITCH_P);
    assign w_right      = r_origin_x + 10'(int'(w_rc) * COL_PITCH_P + SHIP_W_P);
    assign w_at_edge    = r_dir_right ? (w_right + L_STEP_X > L_RIGHT)
                                      : (w_left < L_LEFT + L_STEP_X);
    assign w_new_bottom = r_origin_y + L_STEP_Y + 10'(int'(w_br) * ROW_PITCH_P + SHIP_H_P);

    // Round-robin column scan starting at the fire pointer, then the front ship of that column.
    always_comb begin
        int idx;
        idx          = 0;
        w_fire_found = 1'b0;
        w_fire_col   = '0;
        w_fire_row   = '0;
        for (int k = 0; k < COLS_P; k++) begin
            idx = int'(r_fire_ptr) + k;
            if (idx >= COLS_P) idx = idx - COLS_P;
            if (!w_fire_found && w_col_alive[idx]) begin
                w_fire_found = 1'b1;
                w_fire_col   = COL_W'(idx);
            end
        end
        for (int r = 0; r < ROWS_P; r++) begin
            if (r_alive[r*COLS_P + int'(w_fire_col)]) w_fire_row = ROW_W'(r);
        end
    end

    assign w_spawn_x     = r_origin_x + 10'(int'(w_fire_col) * COL_PITCH_P + SHIP_W_P / 2);
    assign w_spawn_y     = r_origin_y + 10'(int'(w_fire_row) * ROW_PITCH_P + SHIP_H_P);
    assign w_next_ptr    = (int'(w_fire_col) == COLS_P - 1) ? '0 : w_fire_col + 1'b1;
    assign w_bullet_next = r_bullet_y + L_BSTEP;

    always_comb begin
        int idx;
        idx         = int'(hit_row_i) * COLS_P + int'(hit_col_i);
        w_alive_hit = r_alive;
        if (hit_i && idx < N) w_alive_hit[idx] = 1'b0;
    end

`ifdef FLEET_SPEEDUP_EN
    int w_dead, w_period;
    always_comb begin
        w_dead = 0;
        for (int i = 0; i < N; i++) begin
            if (!r_alive[i]) w_dead = w_dead + 1;
        end
        w_period = MOVE_FRAMES_P - 2 * w_dead;
        if (w_period < 2) w_period = 2;
    end
    assign w_move_last = (int'(r_move_cnt) >= w_period - 1);
`else
    assign w_move_last = (int'(r_move_cnt) == MOVE_FRAMES_P - 1);
`endif

    assign w_active = (r_state == MARCH) || (r_state == DESCEND);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state        <= IDLE;
            r_origin_x     <= L_START_X;
            r_origin_y     <= L_START_Y;
            r_alive        <= '0;
            r_dir_right    <= 1'b1;
            r_all_dead     <= 1'b0;
            r_landed       <= 1'b0;
            r_bullet_valid <= 1'b0;
            r_bullet_x     <= '0;
            r_bullet_y     <= '0;
            r_move_cnt     <= '0;
            r_fire_cnt     <= '0;
            r_fire_ptr     <= '0;
        end else if (start_i) begin
            r_state        <= MARCH;
            r_origin_x     <= L_START_X;
            r_origin_y     <= L_START_Y;
            r_alive        <= '1;
            r_dir_right    <= 1'b1;
            r_all_dead     <= 1'b0;
            r_landed       <= 1'b0;
            r_bullet_valid <= 1'b0;
            r_bullet_x     <= '0;
            r_bullet_y     <= '0;
            r_move_cnt     <= '0;
            r_fire_cnt     <= '0;
            r_fire_ptr     <= '0;
        end else if (w_active) begin
            if (frame_i) begin
                if (w_move_last) begin
                    r_move_cnt <= '0;
                    if (r_state == MARCH) begin
                        if (w_at_edge)        r_state    <= DESCEND;
                        else if (r_dir_right) r_origin_x <= r_origin_x + L_STEP_X;
                        else                  r_origin_x <= r_origin_x - L_STEP_X;
                    end else begin
                        r_origin_y  <= r_origin_y + L_STEP_Y;
                        r_dir_right <= !r_dir_right;
                        if (w_new_bottom >= L_LAND) begin
                            r_state  <= LANDED;
                            r_landed <= 1'b1;
                        end else begin
                            r_state  <= MARCH;
                        end
                    end
                end else begin
                    r_move_cnt <= r_move_cnt + 1'b1;
                end

                if (int'(r_fire_cnt) == FIRE_FRAMES_P - 1) begin
                    r_fire_cnt <= '0;
                    if (!r_bullet_valid && w_fire_found) begin
                        r_bullet_valid <= 1'b1;
                        r_bullet_x     <= w_spawn_x;
                        r_bullet_y     <= w_spawn_y;
                        r_fire_ptr     <= w_next_ptr;
                    end
                end else begin
                    r_fire_cnt <= r_fire_cnt + 1'b1;
                end

                if (r_bullet_valid) begin
                    r_bullet_y <= w_bullet_next;
                    if (w_bullet_next >= L_BBOT) r_bullet_valid <= 1'b0;
                end
            end

            if (bullet_clear_i) r_bullet_valid <= 1'b0;

            if (hit_i) begin
                r_alive <= w_alive_hit;
                if (w_alive_hit == '0) begin
                    r_state        <= CLEARED;
                    r_all_dead     <= 1'b1;
                    r_bullet_valid <= 1'b0;
                end
            end
        end
    end

    assign origin_x_o     = r_origin_x;
    assign origin_y_o     = r_origin_y;
    assign alive_o        = r_alive;
    assign dir_right_o    = r_dir_right;
    assign all_dead_o     = r_all_dead;
    assign landed_o       = r_landed;
    assign bullet_valid_o = r_bullet_valid;
    assign bullet_x_o     = r_bullet_x;
    assign bullet_y_o     = r_bullet_y;

endmodule

// File: tb/tb_enemy_fleet.sv
// tb/tb_enemy_fleet.sv - directed self-checking bench for enemy_fleet
// Bullet step is overridden to 2 px so a shot outlives one fire period (lets the skip case occur).
module tb_enemy_fleet;

    logic        clk = 1'b0;
    logic        rst_n, frame, start, hit, bclr;
    logic [1:0]  hrow;
    logic [2:0]  hcol;
    logic [9:0]  ox, oy, bx, by;
    logic [31:0] alive;
    logic        dir_r, all_dead, landed, bv;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    enemy_fleet #(.BULLET_STEP_P(2)) dut (
        .clk_i(clk), .reset_ni(rst_n), .frame_i(frame), .start_i(start),
        .hit_i(hit), .hit_row_i(hrow), .hit_col_i(hcol), .bullet_clear_i(bclr),
        .origin_x_o(ox), .origin_y_o(oy), .alive_o(alive), .dir_right_o(dir_r),
        .all_dead_o(all_dead), .landed_o(landed), .bullet_valid_o(bv),
        .bullet_x_o(bx), .bullet_y_o(by)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame = 1'b1;
            @(negedge clk) frame = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk) bclr = 1'b1;
        @(negedge clk) bclr = 1'b0;
    endtask

    task automatic hit_ship(input int r, input int c);
        @(negedge clk) begin hit = 1'b1; hrow = 2'(r); hcol = 3'(c); end
        @(negedge clk) hit = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " ox"}, 32'(ox), 9);
        check({tag, " oy"}, 32'(oy), 9);
        check({tag, " alive"}, alive, 32'h0);
        check({tag, " dir"}, 32'(dir_r), 1);
        check({tag, " all_dead"}, 32'(all_dead), 0);
        check({tag, " landed"}, 32'(landed), 0);
        check({tag, " bv"}, 32'(bv), 0);
        check({tag, " bx"}, 32'(bx), 0);
        check({tag, " by"}, 32'(by), 0);
    endtask

    initial begin
        rst_n = 1'b0; frame = 1'b0; start = 1'b0; hit = 1'b0; bclr = 1'b0;
        hrow = '0; hcol = '0;
        #12;
        check_reset_values("reset");
        @(negedge clk) rst_n = 1'b1;

        pulse_start();
        check("start alive", alive, 32'hFFFF_FFFF);
        check("start ox", 32'(ox), 9);
        check("start dir", 32'(dir_r), 1);

        frames(29);
        check("ox before first move", 32'(ox), 9);
        frames(1);
        check("ox first move", 32'(ox), 19);

        frames(89);
        check("ox frame 119", 32'(ox), 39);
        check("no bullet before wrap", 32'(bv), 0);
        frames(1);
        check("ox frame 120", 32'(ox), 49);
        check("first shot valid", 32'(bv), 1);
        check("first shot x col0", 32'(bx), 59);
        check("first shot y row3", 32'(by), 119);
        frames(1);
        check("bullet advances", 32'(by), 121);
        pulse_clear();
        check("bullet_clear drops", 32'(bv), 0);

        frames(119);
        check("second shot valid", 32'(bv), 1);
        check("second shot x col1", 32'(bx), 149);
        check("second shot y", 32'(by), 119);

        frames(120);
        check("skip keeps bullet", 32'(bv), 1);
        check("skip keeps x", 32'(bx), 149);
        check("in-flight y", 32'(by), 359);
        pulse_clear();

        frames(120);
        check("third shot x col2", 32'(bx), 279);
        check("third shot y", 32'(by), 119);
        pulse_clear();

        frames(210);
        check("right edge ox", 32'(ox), 239);
        frames(30);
        check("turn no x change", 32'(ox), 239);
        check("turn no y change", 32'(oy), 9);
        check("turn dir unchanged", 32'(dir_r), 1);
        frames(30);
        check("descend oy", 32'(oy), 19);
        check("descend dir", 32'(dir_r), 0);
        check("descend ox", 32'(ox), 239);
        check("not landed", 32'(landed), 0);
        check("bullet live before wipe", 32'(bv), 1);

        hit_ship(2, 3);
        check("hit (2,3)", alive, 32'hFFF7_FFFF);
        hit_ship(2, 3);
        check("repeat hit (2,3)", alive, 32'hFFF7_FFFF);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                hit_ship(r, c);
        check("wipe alive", alive, 32'h0);
        check("wipe all_dead", 32'(all_dead), 1);
        check("wipe bullet dropped", 32'(bv), 0);
        frames(30);
        check("cleared frozen ox", 32'(ox), 239);
        check("cleared frozen oy", 32'(oy), 19);
        check("all_dead sticky", 32'(all_dead), 1);

        pulse_start();
        check("restart all_dead", 32'(all_dead), 0);
        check("restart alive", alive, 32'hFFFF_FFFF);
        check("restart ox", 32'(ox), 9);
        check("restart oy", 32'(oy), 9);
        check("restart dir", 32'(dir_r), 1);
        for (int r = 0; r < 4; r++) hit_ship(r, 7);
        check("col7 dead", alive, 32'h7F7F_7F7F);
        frames(840);
        check("col6 edge ox", 32'(ox), 289);
        frames(30);
        check("col6 turn ox", 32'(ox), 289);
        check("col6 turn oy", 32'(oy), 9);
        check("bullet live in descend", 32'(bv), 1);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async reset");
        @(negedge clk) rst_n = 1'b1;

        pulse_start();
        for (int c = 0; c < 5; c++) hit_ship(3, c);
        check("five dead", alive, 32'hE0FF_FFFF);
`ifdef FLEET_SPEEDUP_EN
        frames(19);
        check("speedup before move", 32'(ox), 9);
        frames(1);
        check("speedup move at 20", 32'(ox), 19);
`else
        frames(20);
        check("fixed period at 20", 32'(ox), 9);
        frames(10);
        check("fixed period at 30", 32'(ox), 19);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
